// File: rtl/pe_mac_unit_pkg.sv
// rtl/pe_mac_unit_pkg.sv - shared PE state encodings and default sizing
// Package pe_pkg: one-hot PE state type and default DATA_W/ACC_W/DONE_DELAY,
// shared by the PE, the systolic-array controller and the array top.
package pe_pkg;

    // One-hot encoding; 4'b1000 is reserved for a future state.
    typedef enum logic [3:0] {
        PE_IDLE = 4'b0001,
        PE_MULT = 4'b0010,
        PE_ACC  = 4'b0100
    } pe_state_t;

    localparam int PE_DATA_W     = 8;
    localparam int PE_ACC_W      = 20;
    localparam int PE_DONE_DELAY = 2;

endpackage

// File: rtl/pe_mac_unit_if.sv
// rtl/pe_mac_unit_if.sv - PE control/operand/result bundle
// Interface pe_mac_unit_if
//   master: drives clr, start, a_in, b_in; observes the PE results
//   slave : the PE; drives a_out, b_out, acc_out, busy, done, delayed_done
interface pe_mac_unit_if
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W
) ();

    logic              clr;
    logic              start;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [ACC_W-1:0]  acc_out;
    logic              busy;
    logic              done;
    logic              delayed_done;

    modport master (
        output clr, start, a_in, b_in,
        input  a_out, b_out, acc_out, busy, done, delayed_done
    );

    modport slave (
        input  clr, start, a_in, b_in,
        output a_out, b_out, acc_out, busy, done, delayed_done
    );

endinterface

// File: rtl/pe_mac_unit_shift_add_mult.sv
// rtl/pe_mac_unit_shift_add_mult.sv - iterative unsigned shift-add multiplier
// Module pe_shift_add_mult
//   clk, rst      : clock, synchronous active-high reset
//   load          : latch a_in/b_in, clear product and bit counter
//   step          : one shift-add iteration on the current multiplier bit
//   a_reg, b_reg  : latched operands (also the PE's forwarded operands)
//   product       : 2*DATA_W-bit partial/final product
//   last          : the step being taken now is the final one
module pe_shift_add_mult
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a_in,
    input  logic [DATA_W-1:0]     b_in,
    output logic [DATA_W-1:0]     a_reg,
    output logic [DATA_W-1:0]     b_reg,
    output logic [2*DATA_W-1:0]   product,
    output logic                  last
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] a_shift;

    assign a_shift = {{DATA_W{1'b0}}, a_reg} << cnt;
    assign last    = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            product <= '0;
            cnt     <= '0;
        end else if (load) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            product <= '0;
            cnt     <= '0;
        end else if (step) begin
            if (b_reg[cnt]) begin
                product <= product + a_shift;
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pe_mac_unit.sv
// rtl/pe_mac_unit.sv - systolic-array processing element (MAC)
// Module pe_mac_unit
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pe_mac_unit_if
//              in : clr, start, a_in, b_in
//              out: a_out, b_out (forwarded operands), acc_out, busy,
//                   done (1-cycle), delayed_done (done + DONE_DELAY cycles)
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int DATA_W     = PE_DATA_W,
    parameter int ACC_W      = PE_ACC_W,
    parameter int DONE_DELAY = PE_DONE_DELAY
) (
    input  logic         clk,
    input  logic         rst,
    pe_mac_unit_if.slave bus
);

    localparam int PROD_W = 2 * DATA_W;

    pe_state_t             state;
    pe_state_t             state_next;
    logic                  mult_load;
    logic                  mult_step;
    logic                  mult_last;
    logic                  acc_upd;
    logic                  acc_clr;
    logic                  busy_c;
    logic [PROD_W-1:0]     product;
    logic [ACC_W-1:0]      prod_ext;
    logic [ACC_W-1:0]      acc;
    logic                  done_q;
    logic [DONE_DELAY-1:0] dly;

    pe_shift_add_mult #(.DATA_W(DATA_W)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .load    (mult_load),
        .step    (mult_step),
        .a_in    (bus.a_in),
        .b_in    (bus.b_in),
        .a_reg   (bus.a_out),
        .b_reg   (bus.b_out),
        .product (product),
        .last    (mult_last)
    );

    // Narrow accumulators drop the product's upper bits before the add.
    generate
        if (ACC_W >= PROD_W) begin : g_prod_zext
            assign prod_ext = ACC_W'(product);
        end else begin : g_prod_trunc
            assign prod_ext = product[ACC_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PE_IDLE: if (bus.start) state_next = PE_MULT;
            PE_MULT: if (mult_last) state_next = PE_ACC;
            PE_ACC:  state_next = PE_IDLE;
            default: state_next = PE_IDLE;
        endcase
    end

    // start and clr are only honoured in IDLE; both may act in the same cycle.
    always_comb begin
        mult_load = 1'b0;
        mult_step = 1'b0;
        acc_upd   = 1'b0;
        acc_clr   = 1'b0;
        busy_c    = 1'b0;
        case (state)
            PE_IDLE: begin
                mult_load = bus.start;
                acc_clr   = bus.clr;
            end
            PE_MULT: begin
                mult_step = 1'b1;
                busy_c    = 1'b1;
            end
            PE_ACC: begin
                acc_upd = 1'b1;
                busy_c  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            done_q <= 1'b0;
            dly    <= '0;
        end else begin
            done_q <= acc_upd;
            if (acc_clr) begin
                acc <= '0;
            end else if (acc_upd) begin
                acc <= acc + prod_ext;
            end
            dly[0] <= done_q;
            for (int i = 1; i < DONE_DELAY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign bus.acc_out      = acc;
    assign bus.busy         = busy_c;
    assign bus.done         = done_q;
    assign bus.delayed_done = dly[DONE_DELAY-1];

endmodule

// File: doc/pe_mac_unit.md
Name: pe_mac_unit

Overview:
- Processing element for the 2x2 systolic array; one instance per array position (PE11, PE12, PE21, PE22).
- Sits directly downstream of the systolic-array controller. It consumes that controller's per-PE start and shared clr, and returns done/delayed_done pulses that drive the controller's next launches.
- Each start latches one operand pair and forwards it registered to the right/lower neighbour. The pair is multiplied with an unsigned shift-add multiplier over DATA_W cycles, and the product is added into a local accumulator.

Parameters:
- DATA_W, 8, operand width (unsigned); also the number of multiply iterations.
- ACC_W, 20, accumulator width; the sum wraps modulo 2^ACC_W.
- DONE_DELAY, 2, cycles between done and delayed_done (must be >= 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous accumulator clear (controller clear state).
- start  in  1  launch one MAC; sampled only in IDLE.
- a_in  in  DATA_W  row operand from left neighbour or feeder.
- b_in  in  DATA_W  column operand from upper neighbour or feeder.
- a_out  out  DATA_W  registered a operand to right neighbour.
- b_out  out  DATA_W  registered b operand to lower neighbour.
- acc_out  out  ACC_W  accumulator value.
- busy  out  1  high in MULT and ACC states.
- done  out  1  one-cycle pulse; the accumulator update has completed.
- delayed_done  out  1  done delayed by DONE_DELAY cycles (to the controller).

Behaviour:
- Reset (rst=1 at an edge): all registers go to 0.
  - Outputs: a_out=0, b_out=0, acc_out=0, busy=0, done=0, delayed_done=0.
  - State goes to IDLE and the delay line is flushed.
  - rst overrides every other input. A reset mid-operation aborts the operation; no done or delayed_done is produced for it.
- States: IDLE, MULT, ACC, one-hot encoded.
- IDLE with start=1 (edge t0):
  - Latch a_in and b_in into the operand regs.
  - a_out <= a_in and b_out <= b_in, visible from t0.
  - Clear the partial product, set bit counter=0, go to MULT.
- MULT: one shift-add step per edge. If the current multiplier bit of b is 1, add the shifted a into the 2*DATA_W-bit product.
  - After DATA_W steps (counter reaches DATA_W-1) go to ACC. MULT therefore occupies edges t1..t(DATA_W).
- ACC (edge t(DATA_W+1)):
  - acc <= acc + zero-extended product, truncated to ACC_W bits (silent wrap, no saturation).
  - done <= 1 and go to IDLE.
  - done is high for exactly one cycle, together with the updated acc_out.
- Latency: done rises DATA_W+1 cycles after the start-sampling edge (9 cycles at default). A new start is accepted on the first cycle after done (IDLE), so back-to-back throughput is one MAC per DATA_W+2 cycles.
- delayed_done: a DONE_DELAY-stage shift register fed by done. It pulses exactly DONE_DELAY cycles after done, and delay-line pulses are unaffected by later starts.
- start while busy: ignored; operands and a_out/b_out are not updated.
- clr in IDLE: acc <= 0 at the next edge.
- clr while busy: ignored; the controller issues clr only from its idle state.
- clr and start together in IDLE: acc <= 0 and the start is accepted; the result accumulates onto 0.
- a_out/b_out hold their value between starts.
- Product width is 2*DATA_W. If ACC_W < 2*DATA_W, the product is truncated before the add.

Decomposition:
- Shared package pe_pkg holds:
  - state encodings PE_IDLE=4'b0001, PE_MULT=4'b0010, PE_ACC=4'b0100 (4'b1000 reserved);
  - default DATA_W/ACC_W/DONE_DELAY constants, which the controller and the array top also use.
- One sub-module, pe_shift_add_mult: the iterative multiplier datapath (operand regs, counter, product register), with a load/step interface driven by the pe_mac_unit FSM.
- The accumulator, FSM and delay line stay in pe_mac_unit.

Test Plan:
- Basic MAC: after rst, start with a_in=3, b_in=4 -> a_out=3 and b_out=4 after t0; busy for 9 cycles; done at t0+9 with acc_out=12; delayed_done at t0+11.
- Accumulate: after the first test, start with a=255, b=255 -> acc_out=65037 at done. Then start with a=0, b=200 -> acc_out unchanged at 65037, done still pulses.
- Wrap: clr, then 17 starts with a=255, b=255 -> acc_out = 1105425 mod 2^20 = 56849 after the last done.
- Start/clr while busy: start with a=7, b=9, then pulse start (a=1, b=1) and clr during MULT -> both ignored, a_out stays 7, acc_out=63 at done (from 0). clr and start together in IDLE with a=2, b=5 -> acc_out=10.
- Reset mid-operation: assert rst during MULT cycle 4 -> next cycle all outputs are 0, no done or delayed_done ever follows, and a fresh start with a=1, b=1 gives acc_out=1.
- Delay line: DONE_DELAY=3, two back-to-back MACs -> each delayed_done is exactly 3 cycles after its done, and there are exactly two pulses.
